// File: rtl/line_fill_engine.sv
// Line fill engine: collects one LINE_WORDS burst into a line register and flags the critical word.
// Enable->AXIStartRead 1 cycle, last beat->LineReadCompleted 1 cycle; beats only when RequestAttended, Enable ignored while Busy; LFE_CRITICAL_WORD_FIRST_EN selects wrap order.
module line_fill_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             Enable,
    input  logic [ADDR_WIDTH-1:0]            Address,
    output logic                             Busy,
    output logic                             AXIStartRead,
    output logic [ADDR_WIDTH-1:0]            AXIAddr,
    output logic                             AXIWrap,
    input  logic [DATA_WIDTH-1:0]            Data,
    input  logic                             RequestAttended,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] Line,
    output logic [ADDR_WIDTH-1:0]            BaseAddress,
    output logic [DATA_WIDTH-1:0]            CriticalWord,
    output logic                             FirstDataAcquired,
    output logic [LINE_WORDS-1:0]            WordValid,
    output logic                             LineReadCompleted
);

    localparam int BO = $clog2(DATA_WIDTH / 8);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int LO = BO + IW;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LO) - ADDR_WIDTH'(1));
    localparam logic [IW-1:0]         LAST_CNT  = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]                  r_crit;
    logic [IW-1:0]                  r_idx;
    logic [IW-1:0]                  r_cnt;
    logic [ADDR_WIDTH-1:0]          r_base;
    logic [ADDR_WIDTH-1:0]          r_axi_addr;
    logic                           r_axi_wrap;
    logic [LINE_WORDS*DATA_WIDTH-1:0] r_line;
    logic [LINE_WORDS-1:0]          r_wv;
    logic [DATA_WIDTH-1:0]          r_cw;
    logic                           r_fda;

    logic                           w_busy;
    logic                           w_start;
    logic                           w_done;
    logic                           w_accept;
    logic                           w_beat;
    logic                           w_last;
    logic [IW-1:0]                  w_crit_in;
    logic [ADDR_WIDTH-1:0]          w_base_in;
    logic [ADDR_WIDTH-1:0]          w_axi_in;
    logic [IW-1:0]                  w_idx_start;
    logic                           w_wrap_in;

    assign w_crit_in = Address[LO-1:BO];
    assign w_base_in = Address & LINE_MASK;

`ifdef LFE_CRITICAL_WORD_FIRST_EN
    // Burst starts at the missing word and wraps, so the critical word arrives first.
    assign w_axi_in    = w_base_in | (ADDR_WIDTH'(w_crit_in) << BO);
    assign w_idx_start = w_crit_in;
    assign w_wrap_in   = 1'b1;
`else
    assign w_axi_in    = w_base_in;
    assign w_idx_start = '0;
    assign w_wrap_in   = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && Enable;
    assign w_beat   = (r_state == S_FILL) && RequestAttended;
    assign w_last   = w_beat && (r_cnt == LAST_CNT);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b1;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (Enable) w_next = S_REQ;
            end
            S_REQ: begin
                w_start = 1'b1;
                w_next  = S_FILL;
            end
            S_FILL: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_crit     <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_base     <= '0;
            r_axi_addr <= '0;
            r_axi_wrap <= 1'b0;
            r_line     <= '0;
            r_wv       <= '0;
            r_cw       <= '0;
            r_fda      <= 1'b0;
        end else begin
            r_fda <= 1'b0;
            if (w_accept) begin
                r_crit     <= w_crit_in;
                r_base     <= w_base_in;
                r_axi_addr <= w_axi_in;
                r_axi_wrap <= w_wrap_in;
                r_idx      <= w_idx_start;
                r_cnt      <= '0;
                r_wv       <= '0;
            end
            // idx is IW bits wide, so the increment wraps modulo LINE_WORDS for free.
            if (w_beat) begin
                r_line[r_idx*DATA_WIDTH +: DATA_WIDTH] <= Data;
                r_wv[r_idx] <= 1'b1;
                r_idx       <= r_idx + 1'b1;
                r_cnt       <= r_cnt + 1'b1;
                if (r_idx == r_crit) begin
                    r_cw  <= Data;
                    r_fda <= 1'b1;
                end
            end
        end
    end

    assign Busy              = w_busy;
    assign AXIStartRead      = w_start;
    assign AXIAddr           = r_axi_addr;
    assign AXIWrap           = r_axi_wrap;
    assign Line              = r_line;
    assign BaseAddress       = r_base;
    assign CriticalWord      = r_cw;
    assign FirstDataAcquired = r_fda;
    assign WordValid         = r_wv;
    assign LineReadCompleted = w_done;

endmodule
